// File: rtl/coletor_medidas.sv
// coletor_medidas: triggers three sensor samples, hands them to a classifier and retries on reject.
// Optional sensor timeout in ESPERA is built only when COLETOR_TIMEOUT_EN is defined.
module coletor_medidas #(
    parameter int INTERVALO      = 1000,
    parameter int MAX_TENTATIVAS = 3,
    parameter int TIMEOUT        = 50000
) (
    input  logic        clock,
    input  logic        zera,
    input  logic        coletar,
    output logic        medir,
    input  logic        sensor_pronto,
    input  logic [11:0] sensor_dado,
    output logic [11:0] medida1,
    output logic [11:0] medida2,
    output logic [11:0] medida3,
    output logic        iniciar,
    input  logic        fim_classificacao,
    input  logic        descartar_medida,
    output logic        ocupado,
    output logic        concluido,
    output logic        falha,
    output logic        erro_sensor,
    output logic [1:0]  tentativa
);
`ifdef COLETOR_TIMEOUT_EN
    localparam int LIM = INTERVALO > TIMEOUT ? INTERVALO : TIMEOUT;
`else
    localparam int LIM = INTERVALO;
`endif
    localparam int CW = $clog2(LIM + 4);
    typedef enum logic [2:0] {OCIOSO, DISPARA, ESPERA, PAUSA, INICIA, AGUARDA} estado_t;
    estado_t estado, proximo;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic          inicio, captura, sai, esgotou, conta;
    assign inicio  = estado == OCIOSO && coletar;
    assign captura = estado == ESPERA && sensor_pronto;
    // cnt saturates at 2 in AGUARDA so a late fim_classificacao still exits
    assign sai     = estado == AGUARDA && cnt >= CW'(2) && fim_classificacao;
    assign esgotou = tentativa >= 2'(MAX_TENTATIVAS);
    assign medir   = estado == DISPARA;
    assign iniciar = estado == INICIA;
    assign ocupado = estado != OCIOSO;
`ifdef COLETOR_TIMEOUT_EN
    logic estouro;
    assign estouro = estado == ESPERA && !sensor_pronto && cnt == CW'(TIMEOUT - 1);
    assign conta   = estado == PAUSA || estado == ESPERA || (estado == AGUARDA && cnt < CW'(2));
    always_ff @(posedge clock or posedge zera) begin
        if (zera) erro_sensor <= 1'b0;
        else if (inicio) erro_sensor <= 1'b0;
        else if (estouro) erro_sensor <= 1'b1;
    end
`else
    assign conta       = estado == PAUSA || (estado == AGUARDA && cnt < CW'(2));
    assign erro_sensor = 1'b0;
`endif
    always_comb begin
        proximo = estado;
        case (estado)
            OCIOSO:  proximo = coletar ? DISPARA : OCIOSO;
            DISPARA: proximo = ESPERA;
            ESPERA: begin
                if (captura) proximo = idx == 2'd2 ? INICIA : PAUSA;
`ifdef COLETOR_TIMEOUT_EN
                else if (estouro) proximo = OCIOSO;
`endif
            end
            PAUSA:   proximo = cnt == CW'(INTERVALO - 1) ? DISPARA : PAUSA;
            INICIA:  proximo = AGUARDA;
            AGUARDA: proximo = !sai ? AGUARDA : (descartar_medida && !esgotou) ? PAUSA : OCIOSO;
            default: proximo = OCIOSO;
        endcase
    end
    always_ff @(posedge clock or posedge zera) begin
        if (zera) begin
            estado <= OCIOSO;
            cnt    <= '0;
        end else begin
            estado <= proximo;
            cnt    <= proximo != estado ? '0 : conta ? cnt + CW'(1) : cnt;
        end
    end
    always_ff @(posedge clock or posedge zera) begin
        if (zera) begin
            idx       <= '0;
            tentativa <= '0;
            falha     <= 1'b0;
            concluido <= 1'b0;
            medida1   <= '0;
            medida2   <= '0;
            medida3   <= '0;
        end else begin
            concluido <= sai && !descartar_medida;
            if (inicio) begin
                idx       <= '0;
                tentativa <= 2'd1;
                falha     <= 1'b0;
            end
            if (captura) begin
                idx     <= idx + 2'd1;
                medida1 <= idx == 2'd0 ? sensor_dado : medida1;
                medida2 <= idx == 2'd1 ? sensor_dado : medida2;
                medida3 <= idx == 2'd2 ? sensor_dado : medida3;
            end
            if (sai && descartar_medida) begin
                if (esgotou) falha <= 1'b1;
                else begin
                    tentativa <= tentativa + 2'd1;
                    idx       <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_coletor_medidas.sv
// tb_coletor_medidas: table of collection requests with a reactive sensor/classifier and a sample scoreboard.
module tb_coletor_medidas;
    localparam int INT = 4;
    localparam int TO  = 10;
    logic        clock = 0, zera = 1, coletar = 0, sensor_pronto = 0;
    logic        fim_classificacao = 0, descartar_medida = 0;
    logic [11:0] sensor_dado = 0;
    logic        medir, iniciar, ocupado, concluido, falha, erro_sensor;
    logic [11:0] medida1, medida2, medida3;
    logic [1:0]  tentativa;

    coletor_medidas #(.INTERVALO(INT), .MAX_TENTATIVAS(3), .TIMEOUT(TO)) dut (
        .clock(clock), .zera(zera), .coletar(coletar), .medir(medir),
        .sensor_pronto(sensor_pronto), .sensor_dado(sensor_dado),
        .medida1(medida1), .medida2(medida2), .medida3(medida3),
        .iniciar(iniciar), .fim_classificacao(fim_classificacao),
        .descartar_medida(descartar_medida), .ocupado(ocupado),
        .concluido(concluido), .falha(falha), .erro_sensor(erro_sensor),
        .tentativa(tentativa)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [11:0] d0, d1, d2;
        int rej;
        bit fixo, esp, aborta;
        int e_medir, e_ini, e_conc;
        bit e_falha;
        int e_tent;
    } caso_t;
    caso_t casos[6];

    int total = 0, bad = 0;
    logic [11:0] expq[$];
    logic [11:0] exp_m[3];
    int midx = 0;
    bit falha_prev = 0;

    task automatic chk(input string nome, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nome, got, exp);
        end
    endtask

    task automatic chk_zero(input string nome);
        chk(nome, {medir, iniciar, ocupado, concluido, falha, erro_sensor, tentativa,
                   medida1, medida2, medida3}, 64'd0);
    endtask

    task automatic executa(input caso_t c, input int id);
        int ult = 0, t_ini = 0, res = 0, amostra = 0, rodada = 0, cap = 0;
        int n_med = 0, n_ini = 0, n_conc = 0, fim_k = -1;
        bit resp = 0, spur = 0, spur_done = 0, resolvido = 0, abortou = 0;
        logic [11:0] v, base;
        chk($sformatf("falha_mantida_%0d", id), falha, falha_prev);
        coletar = 1;
        @(negedge clock);
        coletar = 0;
        chk($sformatf("inicio_%0d", id), {ocupado, falha, tentativa}, {1'b1, 1'b0, 2'd1});
        for (int k = 0; k < 400; k++) begin
            if (sensor_pronto) begin
                if (spur) begin
                    spur = 0;
                    chk("espurio_m1", medida1, exp_m[0]);
                    chk("espurio_m2", medida2, exp_m[1]);
                    chk("espurio_m3", medida3, exp_m[2]);
                end else begin
                    exp_m[midx] = sensor_dado;
                    midx = (midx + 1) % 3;
                end
            end
            sensor_pronto = 0;
            if (c.aborta && amostra == 3 && k == ult + 1) begin
                zera = 1;
                #1;
                chk_zero("zera_em_espera");
                @(negedge clock);
                zera = 0;
                expq.delete();
                exp_m = '{default: 12'd0};
                midx = 0;
                abortou = 1;
                break;
            end
            if (resp) begin
                base = (cap % 3 == 0) ? c.d0 : (cap % 3 == 1) ? c.d1 : c.d2;
                sensor_dado = base + 12'(16 * (cap / 3));
                sensor_pronto = 1;
                expq.push_back(sensor_dado);
                cap++;
                resp = 0;
            end else if (c.esp && !spur_done && amostra == 1 && k == ult + 3) begin
                sensor_dado = 12'hABC;
                sensor_pronto = 1;
                spur = 1;
                spur_done = 1;
            end
            coletar = (k == 7);
            fim_classificacao = c.fixo || (k == fim_k);
            if (medir) begin
                n_med++;
                if (amostra > 0) chk("intervalo_medir", k - ult, INT + 2);
                else if (rodada > 0) chk("atraso_retentativa", k - t_ini, (c.fixo ? 4 : 6) + INT);
                ult = k;
                amostra++;
                resp = !(c.aborta && amostra == 3);
            end
            if (iniciar) begin
                n_ini++;
                for (int i = 0; i < 3; i++) begin
                    if (expq.size() == 0) chk("fila_vazia", 0, 1);
                    else begin
                        v = expq.pop_front();
                        chk($sformatf("medida%0d_caso%0d", i + 1, id),
                            i == 0 ? medida1 : i == 1 ? medida2 : medida3, v);
                    end
                end
                t_ini = k;
                descartar_medida = rodada < c.rej;
                rodada++;
                amostra = 0;
                fim_k = k + 5;
            end
            if (concluido) n_conc++;
            if ((concluido || falha) && !resolvido) begin
                chk($sformatf("latencia_fim_%0d", id), k - t_ini, c.fixo ? 4 : 6);
                resolvido = 1;
                res = k;
            end
            if (resolvido && k == res + 3) break;
            @(negedge clock);
        end
        if (!c.aborta && !resolvido) chk($sformatf("sem_resposta_%0d", id), 0, 1);
        if (c.aborta) chk("zera_executado", abortou, 1);
        fim_classificacao = 0;
        descartar_medida = 0;
        sensor_pronto = 0;
        chk($sformatf("n_medir_%0d", id), n_med, c.e_medir);
        chk($sformatf("n_iniciar_%0d", id), n_ini, c.e_ini);
        chk($sformatf("n_concluido_%0d", id), n_conc, c.e_conc);
        chk($sformatf("falha_%0d", id), falha, c.e_falha);
        chk($sformatf("tentativa_%0d", id), tentativa, c.e_tent);
        chk($sformatf("ocupado_fim_%0d", id), ocupado, 0);
        falha_prev = c.e_falha;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        casos[0] = '{12'd100, 12'd102, 12'd101, 0, 1'b0, 1'b0, 1'b0, 3, 1, 1, 1'b0, 1};
        casos[1] = '{12'd10,  12'd11,  12'd12,  3, 1'b0, 1'b0, 1'b0, 9, 3, 0, 1'b1, 3};
        casos[2] = '{12'd300, 12'd301, 12'd302, 1, 1'b1, 1'b1, 1'b0, 6, 2, 1, 1'b0, 2};
        casos[3] = '{12'd7,   12'd8,   12'd9,   0, 1'b0, 1'b0, 1'b1, 3, 0, 0, 1'b0, 0};
        casos[4] = '{12'd200, 12'd201, 12'd202, 0, 1'b0, 1'b0, 1'b0, 3, 1, 1, 1'b0, 1};
        casos[5] = '{12'd50,  12'd51,  12'd52,  2, 1'b0, 1'b0, 1'b0, 9, 3, 1, 1'b0, 3};
        exp_m = '{default: 12'd0};
        repeat (2) @(negedge clock);
        chk_zero("reset_ativo");
        zera = 0;
        @(negedge clock);
        chk_zero("apos_reset");
        for (int i = 0; i < 6; i++) executa(casos[i], i);
        coletar = 1;
        @(negedge clock);
        coletar = 0;
        chk("medir_silencio", medir, 1);
`ifdef COLETOR_TIMEOUT_EN
        repeat (10) @(negedge clock);
        chk("antes_timeout", {erro_sensor, ocupado}, 2'b01);
        @(negedge clock);
        chk("timeout", {erro_sensor, ocupado, iniciar}, 3'b100);
`else
        repeat (30) @(negedge clock);
        chk("espera_indefinida", {erro_sensor, ocupado, medir, iniciar}, 4'b0100);
`endif
        zera = 1;
        #1;
        chk_zero("zera_final");
        @(negedge clock);
        zera = 0;
        @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/coletor_medidas.md
COLETOR_MEDIDAS -- requirements
Module: coletor_medidas

Interface
REQ-001 The module SHALL have parameter INTERVALO, default 1000: idle clock cycles between sensor triggers, minimum 1.
REQ-002 The module SHALL have parameter MAX_TENTATIVAS, default 3: collection rounds allowed per coletar request, range 1..3.
REQ-003 The module SHALL have parameter TIMEOUT, default 50000: cycles to wait for sensor_pronto (used only with COLETOR_TIMEOUT_EN).
REQ-004 The module SHALL have these ports:
- clock  in  1  single clock; all state changes on its rising edge
- zera  in  1  reset, asynchronous, active-high
- coletar  in  1  start request, sampled in OCIOSO
- medir  out  1  one-cycle trigger to the sensor
- sensor_pronto  in  1  one-cycle strobe: sensor_dado valid
- sensor_dado  in  12  sensor sample
- medida1, medida2, medida3  out  12 each  captured samples, in capture order, to the classifier
- iniciar  out  1  one-cycle start pulse to the classifier
- fim_classificacao  in  1  classifier done level
- descartar_medida  in  1  classifier reject flag
- ocupado  out  1  high in every state except OCIOSO
- concluido  out  1  one-cycle pulse: accepted set available
- falha  out  1  retries exhausted
- erro_sensor  out  1  sensor timeout
- tentativa  out  2  current round number, 1-based

Function
REQ-005 States SHALL be: OCIOSO, DISPARA, ESPERA, PAUSA, INICIA, AGUARDA.
REQ-006 OCIOSO with coletar=1: clear falha and erro_sensor, set tentativa=1, clear the sample index, go to DISPARA.
REQ-007 DISPARA: assert medir for exactly one cycle, then go to ESPERA.
REQ-008 ESPERA with sensor_pronto=1: store sensor_dado into medida[index] and increment index.
- If index was 2, go to INICIA.
- Otherwise go to PAUSA.
REQ-009 PAUSA: count INTERVALO cycles, then go to DISPARA; consecutive medir pulses SHALL be exactly INTERVALO+2 cycles apart when sensor_pronto follows medir by 1 cycle.
REQ-010 sensor_pronto outside ESPERA SHALL be ignored and SHALL NOT modify any medida register.
REQ-011 INICIA: assert iniciar for exactly one cycle, then go to AGUARDA; medida1..3 SHALL be stable from INICIA until the next capture.
REQ-012 AGUARDA SHALL last at least 3 cycles and SHALL exit only on the first cycle, at or after the 3rd, with fim_classificacao=1; descartar_medida SHALL be sampled on that exit cycle.
REQ-013 On exit with descartar_medida=0: pulse concluido for one cycle and go to OCIOSO.
REQ-014 On exit with descartar_medida=1:
- If tentativa<MAX_TENTATIVAS: increment tentativa, clear index, go to PAUSA (then DISPARA).
- Otherwise: set falha=1 and go to OCIOSO.
REQ-015 falha and erro_sensor SHALL hold until the next accepted coletar or zera.
REQ-016 coletar while ocupado=1 SHALL be ignored.
REQ-017 A single sensor_pronto SHALL capture at most one sample.
REQ-018 concluido and falha SHALL never be asserted for the same request.

Reset
REQ-019 zera=1 SHALL immediately force OCIOSO, mid-operation included, and clear the index and all counters.
REQ-020 During and after zera, these outputs SHALL be 0: medir, iniciar, ocupado, concluido, falha, erro_sensor, tentativa, medida1..3.

Configuration
REQ-021 With macro COLETOR_TIMEOUT_EN defined: an ESPERA lasting TIMEOUT cycles without sensor_pronto SHALL set erro_sensor=1 and go to OCIOSO without asserting iniciar.
REQ-022 Without COLETOR_TIMEOUT_EN: ESPERA SHALL wait indefinitely, erro_sensor SHALL be constant 0, and no timeout counter SHALL be built.

Verification
REQ-023 INTERVALO=4, coletar pulse, sensor answers 100, 102, 101 one cycle after each medir:
- medida1..3 = 100, 102, 101.
- One iniciar pulse.
- fim=1 with descartar=0 -> concluido pulse, tentativa=1.
REQ-024 Bench returns descartar=1 twice then 0 (MAX_TENTATIVAS=3): 9 medir pulses in total, tentativa reaches 3, concluido=1, falha=0.
REQ-025 Bench returns descartar=1 three times: falha=1 after the 3rd round, no concluido, ocupado=0; next coletar clears falha.
REQ-026 zera asserted in ESPERA after the 2nd sample: all outputs 0 that same cycle, no iniciar; a new coletar restarts capture at medida1.
REQ-027 With COLETOR_TIMEOUT_EN and TIMEOUT=10, sensor silent: erro_sensor=1 exactly 10 cycles into ESPERA, then OCIOSO; without the macro the block stays in ESPERA.
REQ-028 fim_classificacao held at 1 from a previous round: AGUARDA still lasts exactly 3 cycles before sampling descartar_medida; a spurious sensor_pronto in PAUSA leaves medida registers unchanged.
